// File: rtl/spi_tx_buffer.sv
// rtl/spi_tx_buffer.sv - SPI transmit FIFO popped by a synchronized byte-sent strobe
// Optional sticky underrun flag is built when SPI_TX_UNDERRUN_EN is defined.
module spi_tx_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   send_complete,
  output logic [WIDTH-1:0]       mcu_out,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   underrun,
  input  logic                   underrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mcu_out_q, mcu_out_d;
  logic             sync1_q, sync2_q, sync3_q;

  logic pop_req;
  logic pop;
  logic push;

  always_comb begin
    pop_req   = sync2_q & ~sync3_q;
    pop       = pop_req & (count_q != '0);
    // A full FIFO still accepts a write when a byte leaves on the same edge.
    push      = wr_en & ((count_q != FULL_CNT) | pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mcu_out_d = '0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // The new head may be the byte being written this very edge.
    if (count_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        mcu_out_d = wr_data;
      end else begin
        mcu_out_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mcu_out_q <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      mcu_out_q <= mcu_out_d;
      sync1_q   <= send_complete;
      sync2_q   <= sync1_q;
      sync3_q   <= sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

`ifdef SPI_TX_UNDERRUN_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (underrun_clr) begin
      underrun_d = 1'b0;
    end
    if (pop_req && (count_q == '0)) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  logic unused_underrun_clr;
  assign unused_underrun_clr = underrun_clr;
  assign underrun            = 1'b0;
`endif

  assign mcu_out = mcu_out_q;
  assign count   = count_q;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);

endmodule

// File: tb/tb_spi_tx_buffer.sv
// tb/tb_spi_tx_buffer.sv - self-checking bench for spi_tx_buffer against a queue model
module tb_spi_tx_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       send_complete = 1'b0;
  logic [7:0] mcu_out;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       underrun;
  logic       underrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  int         pop_at[$];
  int         cyc = 0;
  logic       prev_sc = 1'b0;
  logic       m_underrun = 1'b0;

  spi_tx_buffer #(.WIDTH(8), .DEPTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .send_complete(send_complete), .mcu_out(mcu_out), .full(full),
    .empty(empty), .count(count), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mq.delete();
    pop_at.delete();
    prev_sc = 1'b0;
    m_underrun = 1'b0;
  endtask

  // Model: a rise of send_complete seen at edge k tries to pop at edge k+2.
  task automatic step();
    bit pop_try, do_pop, do_push;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      model_clear();
    end else begin
      pop_try = (pop_at.size() > 0) && (pop_at[0] == cyc);
      if (pop_try) void'(pop_at.pop_front());
      if (send_complete && !prev_sc) pop_at.push_back(cyc + 2);
      prev_sc = send_complete;
      do_pop  = pop_try && (mq.size() > 0);
      do_push = wr_en && ((mq.size() < 16) || do_pop);
`ifdef SPI_TX_UNDERRUN_EN
      if (underrun_clr) m_underrun = 1'b0;
      if (pop_try && (mq.size() == 0)) m_underrun = 1'b1;
`endif
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(wr_data);
    end
    #1;
  endtask

  task automatic pulse();
    send_complete = 1'b1;
    step();
    send_complete = 1'b0;
    step();
    step();
  endtask

  function automatic logic [7:0] m_head();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++; if (mcu_out !== 8'h00) begin errors++; $display("FAIL reset_mcu_out: got %h expected 00", mcu_out); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    model_clear();
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_data = 8'h66; step();
    wr_data = 8'h67; step();
    wr_en = 1'b0;
    checks++; if (mcu_out !== 8'h66) begin errors++; $display("FAIL basic_head: got %h expected 66", mcu_out); end
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count); end
    send_complete = 1'b1;
    step();
    checks++; if (mcu_out !== 8'h66) begin errors++; $display("FAIL basic_edge1: got %h expected 66", mcu_out); end
    step();
    checks++; if (mcu_out !== 8'h66) begin errors++; $display("FAIL basic_edge2: got %h expected 66", mcu_out); end
    step();
    checks++; if (mcu_out !== 8'h67) begin errors++; $display("FAIL basic_edge3: got %h expected 67", mcu_out); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL basic_pop_count: got %0d expected 1", count); end
    send_complete = 1'b0;
    step();
    pulse();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL basic_drain: got empty %b expected 1", empty); end
  endtask

  task automatic test_full();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); step();
    end
    wr_en = 1'b0;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b expected 1", full); end
    wr_en = 1'b1; wr_data = 8'hAA; step();
    wr_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_ignore_count: got %0d expected 16", count); end
    checks++; if (mcu_out !== 8'h00) begin errors++; $display("FAIL full_ignore_head: got %h expected 00", mcu_out); end
    for (int i = 0; i < 16; i++) begin
      pulse();
      exp = (i < 15) ? 8'(i + 1) : 8'h00;
      checks++; if (mcu_out !== exp) begin errors++; $display("FAIL full_drain_seq[%0d]: got %h expected %h", i, mcu_out, exp); end
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty: got %b expected 1", empty); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255)); step();
    end
    wr_en = 1'b0;
    send_complete = 1'b1; step();
    send_complete = 1'b0; step();
    wr_en = 1'b1; wr_data = 8'h55; step();
    wr_en = 1'b0;
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL fpp_count: got %0d expected 16", count); end
    for (int i = 0; i < 15; i++) begin
      pulse();
      checks++; if (mcu_out !== m_head()) begin errors++; $display("FAIL fpp_seq[%0d]: got %h expected %h", i, mcu_out, m_head()); end
    end
    checks++; if (mcu_out !== 8'h55) begin errors++; $display("FAIL fpp_last: got %h expected 55", mcu_out); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL fpp_last_count: got %0d expected 1", count); end
    pulse();
  endtask

  task automatic test_underrun();
    logic exp_u;
`ifdef SPI_TX_UNDERRUN_EN
    exp_u = 1'b1;
`else
    exp_u = 1'b0;
`endif
    pulse();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL ur_count: got %0d expected 0", count); end
    checks++; if (mcu_out !== 8'h00) begin errors++; $display("FAIL ur_head: got %h expected 00", mcu_out); end
    checks++; if (underrun !== exp_u) begin errors++; $display("FAIL ur_flag: got %b expected %b", underrun, exp_u); end
    underrun_clr = 1'b1; step();
    underrun_clr = 1'b0;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
    // pop attempt on empty coincident with clear and with a push
    send_complete = 1'b1; step();
    send_complete = 1'b0; step();
    underrun_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h3C; step();
    underrun_clr = 1'b0; wr_en = 1'b0;
    checks++; if (underrun !== exp_u) begin errors++; $display("FAIL ur_set_wins: got %b expected %b", underrun, exp_u); end
    checks++; if (count !== 5'd1) begin errors++; $display("FAIL ur_push_empty_count: got %0d expected 1", count); end
    checks++; if (mcu_out !== 8'h3C) begin errors++; $display("FAIL ur_push_empty_head: got %h expected 3c", mcu_out); end
    pulse();
    underrun_clr = 1'b1; step();
    underrun_clr = 1'b0;
  endtask

  task automatic test_hold_and_wrap();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255)); step();
    end
    wr_en = 1'b0;
    send_complete = 1'b1;
    for (int i = 0; i < 20; i++) step();
    send_complete = 1'b0;
    step();
    checks++; if (count !== 5'd2) begin errors++; $display("FAIL hold_one_pop: got %0d expected 2", count); end
    checks++; if (mcu_out !== m_head()) begin errors++; $display("FAIL hold_head: got %h expected %h", mcu_out, m_head()); end
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(0, 255)); send_complete = 1'b1; step();
      wr_en = 1'b0; send_complete = 1'b0; step();
      step();
      checks++; if (count !== 5'd2) begin errors++; $display("FAIL wrap_count[%0d]: got %0d expected 2", i, count); end
      checks++; if (mcu_out !== m_head()) begin errors++; $display("FAIL wrap_head[%0d]: got %h expected %h", i, mcu_out, m_head()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      wr_en = ($urandom_range(0, 9) < 5);
      wr_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) send_complete = ~send_complete;
      underrun_clr = ($urandom_range(0, 15) == 0);
      step();
      checks++; if (count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, mq.size()); end
      checks++; if (mcu_out !== m_head()) begin errors++; $display("FAIL rnd_head[%0d]: got %h expected %h", i, mcu_out, m_head()); end
      checks++; if (full !== (mq.size() == 16)) begin errors++; $display("FAIL rnd_full[%0d]: got %b expected %b", i, full, mq.size() == 16); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty[%0d]: got %b expected %b", i, empty, mq.size() == 0); end
      checks++; if (underrun !== m_underrun) begin errors++; $display("FAIL rnd_underrun[%0d]: got %b expected %b", i, underrun, m_underrun); end
    end
    wr_en = 1'b0; send_complete = 1'b0; underrun_clr = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    reset_n = 1'b0; step();
    reset_n = 1'b1; step();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom_range(1, 255)); step();
    end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL arst_pre_count: got %0d expected 5", count); end
    send_complete = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_clear();
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %b expected 1", empty); end
    checks++; if (mcu_out !== 8'h00) begin errors++; $display("FAIL arst_head: got %h expected 00", mcu_out); end
    wr_en = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    step();
    // send_complete was high at release: one pop attempt on an empty FIFO
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL arst_release_count: got %0d expected 0", count); end
    checks++; if (underrun !== m_underrun) begin errors++; $display("FAIL arst_release_underrun: got %b expected %b", underrun, m_underrun); end
    send_complete = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_full_push_pop();
    test_underrun();
    test_hold_and_wrap();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
